// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: redirect sequencer in front of pc_reg.
// It picks one redirect from three sources (interrupt > mispredict > execute jump).
// If the instruction bus is busy, the redirect waits in PEND.
// Otherwise it becomes a one-cycle jump, followed by a flush window that squashes
// wrong-path fetches.
// Optional feature: define REDIRECT_PERF_EN to add redirect/pend performance counters.
//
// Handshake: requests are level-sampled every cycle. There is no ready back to the sources;
// a request that loses arbitration or is dropped in PEND/FLUSH is simply not remembered.
// Every output is a flop, so jump_flag_o lands one cycle after the winning request.
module pc_redirect_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int HOLD_W       = 3,
  parameter int HOLD_PC      = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_reset_i,
  input  logic              int_req_i,
  input  logic [ADDR_W-1:0] int_addr_i,
  input  logic              mispred_i,
  input  logic [ADDR_W-1:0] mispred_addr_i,
  input  logic              ex_jump_i,
  input  logic [ADDR_W-1:0] ex_jump_addr_i,
  input  logic [HOLD_W-1:0] ex_hold_i,
  input  logic              ibus_busy_i,
  output logic              jump_flag_o,
  output logic [ADDR_W-1:0] jump_addr_o,
  output logic              predict_error_o,
  output logic [HOLD_W-1:0] hold_flag_o,
  output logic              flush_o,
  output logic [1:0]        redirect_src_o,
  output logic              busy_o,
`ifdef REDIRECT_PERF_EN
  output logic [31:0]       perf_int_o,
  output logic [31:0]       perf_mispred_o,
  output logic [31:0]       perf_ex_o,
  output logic [31:0]       perf_pend_o,
`endif
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, FLUSH = 2'd2} state_e;

  localparam logic [1:0] SRC_INT  = 2'd0;
  localparam logic [1:0] SRC_MIS  = 2'd1;
  localparam logic [1:0] SRC_EX   = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [1:0]        pend_src_q, pend_src_d;
  logic              jump_flag_q, jump_flag_d;
  logic [ADDR_W-1:0] jump_addr_q, jump_addr_d;
  logic              pe_q, pe_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              flush_q, flush_d;
  logic [1:0]        src_q, src_d;
  logic              busy_q, busy_d;

  logic              win_vld;
  logic [1:0]        win_src;
  logic [ADDR_W-1:0] win_addr;
  logic              issue;
  logic [1:0]        iss_src;
  logic [ADDR_W-1:0] iss_addr;
  logic [HOLD_W-1:0] int_hold;

  // Fixed-priority winner among this cycle's requests.
  always_comb begin
    win_vld  = int_req_i | mispred_i | ex_jump_i;
    win_src  = SRC_NONE;
    win_addr = '0;
    if (int_req_i) begin
      win_src  = SRC_INT;
      win_addr = int_addr_i;
    end else if (mispred_i) begin
      win_src  = SRC_MIS;
      win_addr = mispred_addr_i;
    end else if (ex_jump_i) begin
      win_src  = SRC_EX;
      win_addr = ex_jump_addr_i;
    end
  end

  // Next-state, issue decision and next values of all registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_addr_d = pend_addr_q;
    pend_src_d  = pend_src_q;
    jump_flag_d = 1'b0;
    jump_addr_d = jump_addr_q;
    pe_d        = 1'b0;
    flush_d     = 1'b0;
    issue       = 1'b0;
    iss_src     = SRC_NONE;
    iss_addr    = '0;

    case (state_q)
      IDLE: begin
        if (win_vld) begin
          if (!ibus_busy_i) begin
            issue    = 1'b1;
            iss_src  = win_src;
            iss_addr = win_addr;
          end else begin
            state_d     = PEND;
            pend_src_d  = win_src;
            pend_addr_d = win_addr;
          end
        end
      end
      PEND: begin
        // Only a strictly higher-priority request (smaller code) may displace the pending one.
        if (win_vld && (win_src < pend_src_q)) begin
          pend_src_d  = win_src;
          pend_addr_d = win_addr;
        end
        if (!ibus_busy_i) begin
          issue    = 1'b1;
          iss_src  = pend_src_d;
          iss_addr = pend_addr_d;
        end
      end
      FLUSH: begin
        // Execute jumps here are wrong-path; only int/mispred restart the sequence.
        if (int_req_i || mispred_i) begin
          if (!ibus_busy_i) begin
            issue    = 1'b1;
            iss_src  = win_src;
            iss_addr = win_addr;
          end else begin
            state_d     = PEND;
            pend_src_d  = win_src;
            pend_addr_d = win_addr;
          end
        end else if (cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - 3'd1;
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      jump_flag_d = 1'b1;
      jump_addr_d = iss_addr;
      pe_d        = (iss_src == SRC_MIS);
      flush_d     = 1'b1;
      pend_src_d  = SRC_NONE;
      cnt_d       = 3'(FLUSH_CYCLES);
      state_d     = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
    end

    src_d    = issue ? iss_src : ((state_d == PEND) ? pend_src_d : SRC_NONE);
    int_hold = (state_d == PEND) ? HOLD_W'(HOLD_PC) : '0;
    // The jump cycle never carries a hold, so pc_reg always takes the jump.
    hold_d   = issue ? '0 : ((ex_hold_i > int_hold) ? ex_hold_i : int_hold);
    busy_d   = (state_d != IDLE) || flush_d;

    if (jtag_reset_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      pend_addr_d = '0;
      pend_src_d  = SRC_NONE;
      jump_flag_d = 1'b0;
      jump_addr_d = '0;
      pe_d        = 1'b0;
      flush_d     = 1'b0;
      src_d       = SRC_NONE;
      hold_d      = '0;
      busy_d      = 1'b0;
    end
  end

  // State, pending request and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_addr_q <= '0;
      pend_src_q  <= SRC_NONE;
      jump_flag_q <= 1'b0;
      jump_addr_q <= '0;
      pe_q        <= 1'b0;
      hold_q      <= '0;
      flush_q     <= 1'b0;
      src_q       <= SRC_NONE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_addr_q <= pend_addr_d;
      pend_src_q  <= pend_src_d;
      jump_flag_q <= jump_flag_d;
      jump_addr_q <= jump_addr_d;
      pe_q        <= pe_d;
      hold_q      <= hold_d;
      flush_q     <= flush_d;
      src_q       <= src_d;
      busy_q      <= busy_d;
    end
  end

  assign jump_flag_o     = jump_flag_q;
  assign jump_addr_o     = jump_addr_q;
  assign predict_error_o = pe_q;
  assign hold_flag_o     = hold_q;
  assign flush_o         = flush_q;
  assign redirect_src_o  = src_q;
  assign busy_o          = busy_q;
  assign dbg_state_o     = state_q;

`ifdef REDIRECT_PERF_EN
  logic [31:0] perf_int_q, perf_int_d;
  logic [31:0] perf_mis_q, perf_mis_d;
  logic [31:0] perf_ex_q, perf_ex_d;
  logic [31:0] perf_pend_q, perf_pend_d;

  // Saturating counts of issued redirects per source and of cycles spent pending.
  always_comb begin
    perf_int_d  = perf_int_q;
    perf_mis_d  = perf_mis_q;
    perf_ex_d   = perf_ex_q;
    perf_pend_d = perf_pend_q;
    if (issue && (iss_src == SRC_INT) && (perf_int_q != '1)) perf_int_d = perf_int_q + 32'd1;
    if (issue && (iss_src == SRC_MIS) && (perf_mis_q != '1)) perf_mis_d = perf_mis_q + 32'd1;
    if (issue && (iss_src == SRC_EX)  && (perf_ex_q  != '1)) perf_ex_d  = perf_ex_q + 32'd1;
    if ((state_q == PEND) && (perf_pend_q != '1))            perf_pend_d = perf_pend_q + 32'd1;
    if (jtag_reset_i) begin
      perf_int_d  = '0;
      perf_mis_d  = '0;
      perf_ex_d   = '0;
      perf_pend_d = '0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_int_q  <= '0;
      perf_mis_q  <= '0;
      perf_ex_q   <= '0;
      perf_pend_q <= '0;
    end else begin
      perf_int_q  <= perf_int_d;
      perf_mis_q  <= perf_mis_d;
      perf_ex_q   <= perf_ex_d;
      perf_pend_q <= perf_pend_d;
    end
  end

  assign perf_int_o     = perf_int_q;
  assign perf_mispred_o = perf_mis_q;
  assign perf_ex_o      = perf_ex_q;
  assign perf_pend_o    = perf_pend_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed testbench for pc_redirect_ctrl (default parameters, FLUSH_CYCLES=2).
module tb_pc_redirect_ctrl;

  logic        clk;
  logic        rst;
  logic        jtag_reset_i;
  logic        int_req_i;
  logic [31:0] int_addr_i;
  logic        mispred_i;
  logic [31:0] mispred_addr_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic [2:0]  ex_hold_i;
  logic        ibus_busy_i;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        predict_error_o;
  logic [2:0]  hold_flag_o;
  logic        flush_o;
  logic [1:0]  redirect_src_o;
  logic        busy_o;
  logic [1:0]  dbg_state_o;

  int n_cmp;
  int n_err;
  logic [31:0] exp_q[$];

  pc_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .jtag_reset_i    (jtag_reset_i),
    .int_req_i       (int_req_i),
    .int_addr_i      (int_addr_i),
    .mispred_i       (mispred_i),
    .mispred_addr_i  (mispred_addr_i),
    .ex_jump_i       (ex_jump_i),
    .ex_jump_addr_i  (ex_jump_addr_i),
    .ex_hold_i       (ex_hold_i),
    .ibus_busy_i     (ibus_busy_i),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .predict_error_o (predict_error_o),
    .hold_flag_o     (hold_flag_o),
    .flush_o         (flush_o),
    .redirect_src_o  (redirect_src_o),
    .busy_o          (busy_o),
    .dbg_state_o     (dbg_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one clock, sample 1ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    int_req_i = 1'b0;
    mispred_i = 1'b0;
    ex_jump_i = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // scoreboard: every observed jump must match the oldest expected target
  always @(negedge clk) begin
    if (rst && jump_flag_o) begin
      if (exp_q.size() == 0) check("jump_unexp", {31'b0, jump_flag_o}, 32'd0);
      else check("jump_sb", jump_addr_o, exp_q.pop_front());
    end
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    jtag_reset_i = 1'b0;
    clear_reqs();
    int_addr_i = '0;
    mispred_addr_i = '0;
    ex_jump_addr_i = '0;
    ex_hold_i = '0;
    ibus_busy_i = 1'b0;
    #12;
    check("rst_jump", {31'b0, jump_flag_o}, 32'd0);
    check("rst_addr", jump_addr_o, 32'd0);
    check("rst_src", {30'b0, redirect_src_o}, 32'd3);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_state", {30'b0, dbg_state_o}, 32'd0);
    rst = 1'b1;
    tick();

    // hold passthrough in IDLE
    ex_hold_i = 3'd2;
    tick();
    check("hold_pass", {29'b0, hold_flag_o}, 32'd2);

    // 1: ex jump, bus idle; jump cycle masks the hold
    ex_hold_i = 3'd4;
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h100;
    exp_q.push_back(32'h100);
    tick();
    clear_reqs();
    check("t1_jump", {31'b0, jump_flag_o}, 32'd1);
    check("t1_addr", jump_addr_o, 32'h100);
    check("t1_pe", {31'b0, predict_error_o}, 32'd0);
    check("t1_flush0", {31'b0, flush_o}, 32'd1);
    check("t1_src", {30'b0, redirect_src_o}, 32'd2);
    check("t1_hold_jump", {29'b0, hold_flag_o}, 32'd0);
    tick();
    check("t1_jump_once", {31'b0, jump_flag_o}, 32'd0);
    check("t1_addr_keep", jump_addr_o, 32'h100);
    check("t1_flush1", {31'b0, flush_o}, 32'd1);
    check("t1_hold_back", {29'b0, hold_flag_o}, 32'd4);
    ex_hold_i = 3'd0;
    tick();
    check("t1_flush2", {31'b0, flush_o}, 32'd1);
    tick();
    check("t1_flush_end", {31'b0, flush_o}, 32'd0);
    check("t1_idle", {31'b0, busy_o}, 32'd0);

    // 2: mispred with bus busy for 3 cycles
    mispred_i = 1'b1; mispred_addr_i = 32'h200; ibus_busy_i = 1'b1;
    tick();
    clear_reqs();
    check("t2_pend_state", {30'b0, dbg_state_o}, 32'd1);
    check("t2_hold1", {29'b0, hold_flag_o}, 32'd1);
    check("t2_src", {30'b0, redirect_src_o}, 32'd1);
    check("t2_busy", {31'b0, busy_o}, 32'd1);
    tick();
    check("t2_hold2", {29'b0, hold_flag_o}, 32'd1);
    tick();
    check("t2_hold3", {29'b0, hold_flag_o}, 32'd1);
    check("t2_nojump", {31'b0, jump_flag_o}, 32'd0);
    ibus_busy_i = 1'b0;
    exp_q.push_back(32'h200);
    tick();
    check("t2_jump", {31'b0, jump_flag_o}, 32'd1);
    check("t2_addr", jump_addr_o, 32'h200);
    check("t2_pe", {31'b0, predict_error_o}, 32'd1);
    check("t2_hold_jump", {29'b0, hold_flag_o}, 32'd0);
    tick();
    check("t2_pe_once", {31'b0, predict_error_o}, 32'd0);
    drain(3);

    // 3: replacement in PEND
    mispred_i = 1'b1; mispred_addr_i = 32'h200; ibus_busy_i = 1'b1;
    tick();
    clear_reqs();
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h300;
    tick();
    ex_jump_i = 1'b0;
    check("t3_ex_dropped", {30'b0, redirect_src_o}, 32'd1);
    int_req_i = 1'b1; int_addr_i = 32'h80;
    tick();
    clear_reqs();
    check("t3_replaced", {30'b0, redirect_src_o}, 32'd0);
    ibus_busy_i = 1'b0;
    exp_q.push_back(32'h80);
    tick();
    check("t3_jump", {31'b0, jump_flag_o}, 32'd1);
    check("t3_addr", jump_addr_o, 32'h80);
    check("t3_src", {30'b0, redirect_src_o}, 32'd0);
    check("t3_pe", {31'b0, predict_error_o}, 32'd0);
    drain(3);

    // 4: requests during FLUSH
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h100;
    exp_q.push_back(32'h100);
    tick();
    ex_jump_addr_i = 32'h300;
    tick();
    clear_reqs();
    check("t4_ex_ignored", {31'b0, jump_flag_o}, 32'd0);
    check("t4_addr_keep", jump_addr_o, 32'h100);
    int_req_i = 1'b1; int_addr_i = 32'h80;
    exp_q.push_back(32'h80);
    tick();
    clear_reqs();
    check("t4_int_jump", {31'b0, jump_flag_o}, 32'd1);
    check("t4_int_addr", jump_addr_o, 32'h80);
    tick();
    check("t4_restart1", {31'b0, flush_o}, 32'd1);
    tick();
    check("t4_restart2", {31'b0, flush_o}, 32'd1);
    tick();
    check("t4_restart_end", {31'b0, flush_o}, 32'd0);

    // 5: all three at once
    int_req_i = 1'b1; int_addr_i = 32'h44;
    mispred_i = 1'b1; mispred_addr_i = 32'h55;
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h66;
    exp_q.push_back(32'h44);
    tick();
    clear_reqs();
    check("t5_addr", jump_addr_o, 32'h44);
    check("t5_src", {30'b0, redirect_src_o}, 32'd0);
    check("t5_pe", {31'b0, predict_error_o}, 32'd0);
    drain(3);

    // 6: async reset mid-PEND
    mispred_i = 1'b1; mispred_addr_i = 32'h200; ibus_busy_i = 1'b1;
    tick();
    clear_reqs();
    check("t6_pend", {30'b0, dbg_state_o}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t6_hold", {29'b0, hold_flag_o}, 32'd0);
    check("t6_src", {30'b0, redirect_src_o}, 32'd3);
    check("t6_busy", {31'b0, busy_o}, 32'd0);
    check("t6_state", {30'b0, dbg_state_o}, 32'd0);
    check("t6_addr", jump_addr_o, 32'd0);
    ibus_busy_i = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t6_stay_idle", {31'b0, jump_flag_o}, 32'd0);

    // 7: jtag reset mid-FLUSH
    ex_jump_i = 1'b1; ex_jump_addr_i = 32'h140;
    exp_q.push_back(32'h140);
    tick();
    clear_reqs();
    tick();
    check("t7_in_flush", {30'b0, dbg_state_o}, 32'd2);
    jtag_reset_i = 1'b1;
    tick();
    jtag_reset_i = 1'b0;
    check("t7_state", {30'b0, dbg_state_o}, 32'd0);
    check("t7_flush", {31'b0, flush_o}, 32'd0);
    check("t7_busy", {31'b0, busy_o}, 32'd0);
    check("t7_addr", jump_addr_o, 32'd0);
    tick();
    check("t7_idle", {31'b0, flush_o}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
Redirect sequencer in front of pc_reg. It arbitrates PC redirect requests from three sources: interrupt/exception, branch-mispredict correction, and execute-stage jump. It holds a redirect pending while the instruction bus has a transaction in flight, then issues a single-cycle jump to pc_reg. After the jump it asserts a flush window that squashes wrong-path fetches.

Parameters:
ADDR_W, 32, instruction address width
HOLD_W, 3, hold flag bus width
HOLD_PC, 1, hold level that freezes the PC (hold_flag >= HOLD_PC stalls pc_reg)
FLUSH_CYCLES, 2, flush window length after an issued jump; 0..7 allowed

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
jtag_reset_i  in  1  synchronous soft reset from debug
int_req_i  in  1  interrupt/exception redirect request (priority 0, highest)
int_addr_i  in  ADDR_W  interrupt target
mispred_i  in  1  branch predictor error (priority 1)
mispred_addr_i  in  ADDR_W  corrected target
ex_jump_i  in  1  execute-stage jump (priority 2, lowest)
ex_jump_addr_i  in  ADDR_W  jump target
ex_hold_i  in  HOLD_W  hold request from downstream stages
ibus_busy_i  in  1  instruction bus transaction outstanding
jump_flag_o  out  1  to pc_reg jump_flag_i
jump_addr_o  out  ADDR_W  to pc_reg jump_addr_i
predict_error_o  out  1  to pc_reg predict_error_i
hold_flag_o  out  HOLD_W  to pc_reg hold_flag_i
flush_o  out  1  squash IF/ID contents
redirect_src_o  out  2  source of the current or pending redirect: 0=int, 1=mispred, 2=ex, 3=none
busy_o  out  1  redirect pending or flush window active

Behaviour:
- Reset (rst low, async) or jtag_reset_i (sync):
  - state IDLE
  - jump_flag_o=0, jump_addr_o=0, predict_error_o=0, flush_o=0
  - hold_flag_o=0, redirect_src_o=3, busy_o=0
  - pending registers cleared
- FSM states: IDLE, PEND, FLUSH.
- Winner selection: the highest-priority asserted request in a cycle; int > mispred > ex.
- IDLE, winner present:
  - ibus_busy_i=0: next cycle jump_flag_o=1 and jump_addr_o=target for exactly one cycle. predict_error_o=1 in the same cycle only if src=mispred. flush_o=1. Go to FLUSH with counter=FLUSH_CYCLES.
  - ibus_busy_i=1: latch target/src, go to PEND.
- PEND:
  - hold_flag_o forced to at least HOLD_PC.
  - A new request with strictly higher priority replaces the pending one. Equal or lower priority is dropped.
  - When ibus_busy_i=0, issue as from IDLE on the next cycle.
- FLUSH:
  - flush_o=1.
  - Counter decrements each cycle; return to IDLE when it reaches 0.
  - ex_jump_i is ignored (wrong-path).
  - int_req_i or mispred_i restarts the sequence: issue if the bus is idle, otherwise go to PEND.
- FLUSH_CYCLES=0: FLUSH state is skipped; flush_o is high only in the jump cycle.
- Latency: request at cycle N with the bus idle produces jump_flag_o at N+1, and pc_reg loads the target at the N+2 edge.
- hold_flag_o (registered) is the maximum of ex_hold_i and the internal hold, except that it is 0 in the jump cycle. This ensures the jump is not masked.
- jump_addr_o keeps its last value when jump_flag_o=0.
- All outputs are registered.

Optional Feature:
REDIRECT_PERF_EN
- Defined: adds three 32-bit saturating counters (int, mispred, ex) counting issued redirects, plus a 32-bit counter of PEND cycles.
- Counters are exposed on output ports perf_int_o, perf_mispred_o, perf_ex_o, perf_pend_o.
- Counters clear on reset and on jtag_reset_i.
- Not defined: these ports and all counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- ex_jump_i=1, addr=0x100, bus idle at cycle N
  -> jump_flag_o=1 and jump_addr_o=0x100 at N+1 only; predict_error_o=0; flush_o high for N+1..N+3 (FLUSH_CYCLES=2).
- mispred_i=1, addr=0x200 with ibus_busy_i=1 for 3 cycles
  -> PEND, hold_flag_o>=1 for 3 cycles; after the bus is released, jump to 0x200 with predict_error_o=1 for one cycle.
- In PEND with mispred 0x200 pending, int_req_i=1, addr=0x80
  -> replaced; issued jump 0x80, redirect_src_o=0. ex_jump_i in PEND -> dropped.
- In FLUSH, ex_jump_i=1, addr=0x300 -> ignored. In FLUSH, int_req_i=1, addr=0x80 -> new jump to 0x80 and flush restarts.
- All three requests in the same cycle -> only int target issued.
- rst low mid-PEND -> all outputs at reset values immediately (async).
- jtag_reset_i mid-FLUSH -> IDLE at the next edge.
